// File: rtl/mips_cpu_core.sv
// Single-cycle MIPS-subset core: combinational fetch/decode/execute against an internal
// register file and data memory, with a registered one-cycle retire/writeback status port.
module mips_cpu_core #(
  parameter int unsigned DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_en,
  output logic [31:0] pc,
  input  logic [31:0] inst,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic [31:0] retired_pc,
  output logic        opr_done
);

  localparam int unsigned AW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_WORDS];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val, imm_sext, imm_zext, pc_plus4, addr_sum;
  logic [AW-1:0] dmem_idx;

  assign opcode   = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign shamt    = inst[10:6];
  assign funct    = inst[5:0];
  assign imm      = inst[15:0];
  assign rs_val   = regs[rs];
  assign rt_val   = regs[rt];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  assign pc_plus4 = pc + 32'd4;
  assign addr_sum = rs_val + imm_sext;
  assign dmem_idx = addr_sum[AW+1:2];

  logic        rf_we_c, mem_we_c, halt_c;
  logic [4:0]  dest_c;
  logic [31:0] result_c, wb_data_c, next_pc_c;

  // Decode and execute the current instruction
  always_comb begin
    rf_we_c   = 1'b0;
    mem_we_c  = 1'b0;
    halt_c    = 1'b0;
    dest_c    = 5'd0;
    result_c  = 32'd0;
    wb_data_c = 32'd0;
    next_pc_c = pc_plus4;
    unique case (opcode)
      OP_RTYPE: begin
        rf_we_c = 1'b1;
        dest_c  = rd;
        unique case (funct)
          FN_ADD:  result_c = rs_val + rt_val;
          FN_SUB:  result_c = rs_val - rt_val;
          FN_AND:  result_c = rs_val & rt_val;
          FN_OR:   result_c = rs_val | rt_val;
          FN_XOR:  result_c = rs_val ^ rt_val;
          FN_SLT:  result_c = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
          FN_SLL:  result_c = rt_val << shamt;
          FN_SRL:  result_c = rt_val >> shamt;
          FN_SYSCALL: begin
            rf_we_c   = 1'b0;
            halt_c    = 1'b1;
            next_pc_c = pc;
          end
          default: rf_we_c = 1'b0;
        endcase
      end
      OP_ADDI: begin rf_we_c = 1'b1; dest_c = rt; result_c = rs_val + imm_sext; end
      OP_ANDI: begin rf_we_c = 1'b1; dest_c = rt; result_c = rs_val & imm_zext; end
      OP_ORI:  begin rf_we_c = 1'b1; dest_c = rt; result_c = rs_val | imm_zext; end
      OP_LUI:  begin rf_we_c = 1'b1; dest_c = rt; result_c = {imm, 16'h0000}; end
      OP_LW:   begin rf_we_c = 1'b1; dest_c = rt; result_c = dmem[dmem_idx]; end
      OP_SW: begin
        mem_we_c  = 1'b1;
        wb_data_c = addr_sum;
      end
      OP_BEQ: if (rs_val == rt_val) next_pc_c = pc_plus4 + {imm_sext[29:0], 2'b00};
      OP_BNE: if (rs_val != rt_val) next_pc_c = pc_plus4 + {imm_sext[29:0], 2'b00};
      OP_J:   next_pc_c = {pc_plus4[31:28], inst[25:0], 2'b00};
      default: ;
    endcase
    if (rf_we_c) wb_data_c = result_c;
  end

  logic exec;
  assign exec = pc_en && !opr_done;

  // Architectural state and retire status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_reg     <= 5'd0;
      wb_data    <= 32'd0;
      retired_pc <= 32'd0;
      opr_done   <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      wb_valid <= 1'b0;
      if (exec) begin
        pc         <= next_pc_c;
        wb_valid   <= 1'b1;
        wb_we      <= rf_we_c && (dest_c != 5'd0);
        wb_reg     <= (rf_we_c && (dest_c != 5'd0)) ? dest_c : 5'd0;
        wb_data    <= wb_data_c;
        retired_pc <= pc;
        if (halt_c) opr_done <= 1'b1;
        if (rf_we_c && (dest_c != 5'd0)) regs[dest_c] <= result_c;
      end
    end
  end

  // Data memory has no reset; a store is suppressed while reset is held
  always_ff @(posedge clk) begin
    if (reset && exec && mem_we_c) dmem[dmem_idx] <= rt_val;
  end

endmodule

// File: tb/tb_mips_cpu_core.sv
// Bench for mips_cpu_core: directed vector table, hand-written multi-cycle sequences,
// and randomized instructions checked against an ISA-level reference model.
module tb_mips_cpu_core;

  localparam int unsigned DW = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_en;
  logic [31:0] inst;
  logic [31:0] pc, wb_data, retired_pc;
  logic        wb_valid, wb_we, opr_done;
  logic [4:0]  wb_reg;

  always #5 clk = ~clk;

  mips_cpu_core #(.DMEM_WORDS(DW), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .pc(pc), .inst(inst),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .retired_pc(retired_pc), .opr_done(opr_done)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input logic en, input logic [31:0] i);
    pc_en = en;
    inst  = i;
    @(posedge clk);
    #1;
  endtask

  // ISA-level reference model
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [DW];
  logic [31:0] m_pc;
  logic        m_done;
  logic        e_valid, e_we, e_chkd;
  logic [4:0]  e_reg;
  logic [31:0] e_data, e_rpc;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    m_pc = 32'd0; m_done = 1'b0; e_valid = 1'b0;
  endtask

  task automatic model_exec(input logic en, input logic [31:0] i);
    logic [31:0] a, b, se, ze, res, addr, nxt;
    int dst;
    if (!en || m_done) begin
      e_valid = 1'b0;
      return;
    end
    a = m_regs[i[25:21]];
    b = m_regs[i[20:16]];
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'h0, i[15:0]};
    nxt = m_pc + 32'd4;
    dst = -1; res = 32'd0;
    e_valid = 1'b1; e_we = 1'b0; e_reg = 5'd0; e_data = 32'd0; e_rpc = m_pc; e_chkd = 1'b1;
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h20: begin res = a + b; dst = int'(i[15:11]); end
        6'h22: begin res = a - b; dst = int'(i[15:11]); end
        6'h24: begin res = a & b; dst = int'(i[15:11]); end
        6'h25: begin res = a | b; dst = int'(i[15:11]); end
        6'h26: begin res = a ^ b; dst = int'(i[15:11]); end
        6'h2A: begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; dst = int'(i[15:11]); end
        6'h00: begin res = b << i[10:6]; dst = int'(i[15:11]); end
        6'h02: begin res = b >> i[10:6]; dst = int'(i[15:11]); end
        6'h0C: begin nxt = m_pc; m_done = 1'b1; end
        default: ;
      endcase
      6'h08: begin res = a + se; dst = int'(i[20:16]); end
      6'h0C: begin res = a & ze; dst = int'(i[20:16]); end
      6'h0D: begin res = a | ze; dst = int'(i[20:16]); end
      6'h0F: begin res = {i[15:0], 16'h0}; dst = int'(i[20:16]); end
      6'h23: begin addr = a + se; res = m_mem[(addr / 4) % DW]; dst = int'(i[20:16]); end
      6'h2B: begin addr = a + se; m_mem[(addr / 4) % DW] = b; e_data = addr; end
      6'h04: if (a == b) nxt = m_pc + 32'd4 + se * 32'd4;
      6'h05: if (a != b) nxt = m_pc + 32'd4 + se * 32'd4;
      6'h02: nxt = {nxt[31:28], i[25:0], 2'b00};
      default: ;
    endcase
    if (dst >= 0) begin
      e_data = res;
      if (dst != 0) begin
        e_we = 1'b1; e_reg = dst[4:0]; m_regs[dst[4:0]] = res;
      end else e_chkd = 1'b0;
    end
    m_pc = nxt;
  endtask

  task automatic run_checked(input logic en, input logic [31:0] i);
    model_exec(en, i);
    step(en, i);
    chk("m_valid", 32'(wb_valid), 32'(e_valid));
    chk("m_pc", pc, m_pc);
    chk("m_done", 32'(opr_done), 32'(m_done));
    if (e_valid) begin
      chk("m_we", 32'(wb_we), 32'(e_we));
      chk("m_reg", 32'(wb_reg), 32'(e_reg));
      chk("m_rpc", retired_pc, e_rpc);
      if (e_chkd) chk("m_data", wb_data, e_data);
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [5:0]  fn;
    int k;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
    imm = 16'($urandom);
    k = $urandom_range(0, 17);
    fn = 6'h3F;
    case (k)
      0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
      4: fn = 6'h26; 5: fn = 6'h2A; 6: fn = 6'h00; 7: fn = 6'h02;
      default: ;
    endcase
    case (k)
      8:  return {6'h08, rs, rt, imm};
      9:  return {6'h0C, rs, rt, imm};
      10: return {6'h0D, rs, rt, imm};
      11: return {6'h0F, rs, rt, imm};
      12: return {6'h23, rs, rt, imm};
      13: return {6'h2B, rs, rt, imm};
      14: return {6'h04, rs, ($urandom_range(0, 1) != 0) ? rs : rt, imm};
      15: return {6'h05, rs, ($urandom_range(0, 1) != 0) ? rs : rt, imm};
      16: return {6'h02, 26'($urandom)};
      17: return ($urandom_range(0, 1) != 0) ? {6'h3F, 26'($urandom)} : {6'h00, rs, rt, rd, sh, 6'h3F};
      default: return {6'h00, rs, rt, rd, sh, fn};
    endcase
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic        we;
    logic [4:0]  rg;
    logic [31:0] data;
    logic        chk_data;
    logic [31:0] npc;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [31:0] prev_pc;
    tbl[0]  = '{32'h20010005, 1'b1, 5'd1,  32'h00000005, 1'b1, 32'h004}; // ADDI $1,$0,5
    tbl[1]  = '{32'h2002FFFD, 1'b1, 5'd2,  32'hFFFFFFFD, 1'b1, 32'h008}; // ADDI $2,$0,-3
    tbl[2]  = '{32'h00221820, 1'b1, 5'd3,  32'h00000002, 1'b1, 32'h00C}; // ADD $3,$1,$2
    tbl[3]  = '{32'h00412022, 1'b1, 5'd4,  32'hFFFFFFF8, 1'b1, 32'h010}; // SUB $4,$2,$1
    tbl[4]  = '{32'h0041282A, 1'b1, 5'd5,  32'h00000001, 1'b1, 32'h014}; // SLT $5,$2,$1
    tbl[5]  = '{32'h20000007, 1'b0, 5'd0,  32'h00000000, 1'b0, 32'h018}; // ADDI $0,$0,7
    tbl[6]  = '{32'h00013825, 1'b1, 5'd7,  32'h00000005, 1'b1, 32'h01C}; // OR $7,$0,$1
    tbl[7]  = '{32'hAC010008, 1'b0, 5'd0,  32'h00000008, 1'b1, 32'h020}; // SW $1,8($0)
    tbl[8]  = '{32'h8C060008, 1'b1, 5'd6,  32'h00000005, 1'b1, 32'h024}; // LW $6,8($0)
    tbl[9]  = '{32'h8C080408, 1'b1, 5'd8,  32'h00000005, 1'b1, 32'h028}; // LW $8,0x408($0)
    tbl[10] = '{32'h10210003, 1'b0, 5'd0,  32'h00000000, 1'b1, 32'h038}; // BEQ $1,$1,+3
    tbl[11] = '{32'h14210003, 1'b0, 5'd0,  32'h00000000, 1'b1, 32'h03C}; // BNE $1,$1,+3
    tbl[12] = '{32'h08000040, 1'b0, 5'd0,  32'h00000000, 1'b1, 32'h100}; // J 0x40
    tbl[13] = '{32'h3C091234, 1'b1, 5'd9,  32'h12340000, 1'b1, 32'h104}; // LUI $9,0x1234
    tbl[14] = '{32'h304AFFFF, 1'b1, 5'd10, 32'h0000FFFD, 1'b1, 32'h108}; // ANDI $10,$2,0xFFFF
    tbl[15] = '{32'h00025902, 1'b1, 5'd11, 32'h0FFFFFFF, 1'b1, 32'h10C}; // SRL $11,$2,4
    tbl[16] = '{32'hFC000000, 1'b0, 5'd0,  32'h00000000, 1'b1, 32'h110}; // illegal opcode
    tbl[17] = '{32'h1000FFFC, 1'b0, 5'd0,  32'h00000000, 1'b1, 32'h104}; // BEQ $0,$0,-4

    reset = 1'b0; pc_en = 1'b1; inst = 32'h20010005;
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(wb_valid), 32'h0);
    chk("rst_we", 32'(wb_we), 32'h0);
    chk("rst_reg", 32'(wb_reg), 32'h0);
    chk("rst_data", wb_data, 32'h0);
    chk("rst_rpc", retired_pc, 32'h0);
    chk("rst_done", 32'(opr_done), 32'h0);
    #10 reset = 1'b1;

    prev_pc = 32'h0;
    for (int v = 0; v < 18; v++) begin
      step(1'b1, tbl[v].ins);
      chk($sformatf("v%0d_valid", v), 32'(wb_valid), 32'h1);
      chk($sformatf("v%0d_we", v), 32'(wb_we), 32'(tbl[v].we));
      chk($sformatf("v%0d_reg", v), 32'(wb_reg), 32'(tbl[v].rg));
      if (tbl[v].chk_data) chk($sformatf("v%0d_data", v), wb_data, tbl[v].data);
      chk($sformatf("v%0d_rpc", v), retired_pc, prev_pc);
      chk($sformatf("v%0d_pc", v), pc, tbl[v].npc);
      prev_pc = tbl[v].npc;
    end

    // Freeze with pc_en low, then confirm $1 survived
    for (int f = 0; f < 3; f++) begin
      step(1'b0, 32'h20010063);
      chk("frz_valid", 32'(wb_valid), 32'h0);
      chk("frz_pc", pc, 32'h104);
    end
    step(1'b1, 32'h00206020);
    chk("frz_add_data", wb_data, 32'h5);
    chk("frz_add_reg", 32'(wb_reg), 32'd12);
    chk("frz_add_pc", pc, 32'h108);

    // HALT then stay frozen
    step(1'b1, 32'h0000000C);
    chk("halt_valid", 32'(wb_valid), 32'h1);
    chk("halt_we", 32'(wb_we), 32'h0);
    chk("halt_done", 32'(opr_done), 32'h1);
    chk("halt_pc", pc, 32'h108);
    chk("halt_rpc", retired_pc, 32'h108);
    for (int h = 0; h < 5; h++) begin
      step(1'b1, rand_inst());
      chk("post_halt_valid", 32'(wb_valid), 32'h0);
      chk("post_halt_pc", pc, 32'h108);
      chk("post_halt_done", 32'(opr_done), 32'h1);
    end

    // Asynchronous reset between edges
    #1 reset = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_done", 32'(opr_done), 32'h0);
    chk("arst_valid", 32'(wb_valid), 32'h0);
    chk("arst_data", wb_data, 32'h0);
    #1 reset = 1'b1;
    model_reset();
    model_exec(1'b1, 32'h00226820);
    step(1'b1, 32'h00226820);
    chk("arst_add_data", wb_data, 32'h0);
    chk("arst_add_reg", 32'(wb_reg), 32'd13);
    chk("arst_add_rpc", retired_pc, 32'h0);
    chk("arst_add_pc", pc, 32'h4);

    // Clear all of data memory through stores so the model knows every word
    for (int w = 0; w < int'(DW); w++) run_checked(1'b1, {6'h2B, 5'd0, 5'd0, 16'(w * 4)});

    for (int r = 0; r < 400; r++) run_checked($urandom_range(0, 9) != 0, rand_inst());

    run_checked(1'b1, 32'h0000000C);
    for (int h = 0; h < 3; h++) run_checked(1'b1, rand_inst());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
